// File: rtl/dma_rd_arbiter.sv
// Two-requester burst-read arbiter onto one Avalon-MM read port.
// Tags each accepted burst so return beats route back to their owner.
module dma_rd_arbiter #(
    parameter int TAG_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        desc_read_i,
    input  logic [31:0] desc_addr_i,
    input  logic [3:0]  desc_bcount_i,
    output logic        desc_waitrequest_o,
    output logic [31:0] desc_rddata_o,
    output logic        desc_readdatavalid_o,

    input  logic        data_read_i,
    input  logic [31:0] data_addr_i,
    input  logic [3:0]  data_bcount_i,
    output logic        data_waitrequest_o,
    output logic [31:0] data_rddata_o,
    output logic        data_readdatavalid_o,

    output logic        mem_read_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_bcount_o,
    input  logic        mem_waitrequest_i,
    input  logic [31:0] mem_rddata_i,
    input  logic        mem_readdatavalid_i,

    output logic        busy_o,
    output logic        error_o
);

    localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] GNT_DESC = 2'd1;
    localparam logic [1:0] GNT_DATA = 2'd2;

    localparam logic OWN_DESC = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = TAG_DEPTH[AW:0];

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [3:0]    beat_q, beat_d;
    logic          err_q, err_d;

    logic          tag_own_q [TAG_DEPTH];
    logic [3:0]    tag_len_q [TAG_DEPTH];

    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;
    logic          beat_ok;
    logic          head_own;
    logic [3:0]    acc_len;
    logic [3:0]    beat_inc;

    assign full     = (cnt_q == CNT_FULL);
    assign empty    = (cnt_q == '0);
    assign head_own = tag_own_q[rd_q];
    assign beat_inc = beat_q + 4'd1;

    assign accept = !reset && (state_q != IDLE) && !mem_waitrequest_i;
    assign push   = accept;

    // A zero burst count still returns one beat
    assign acc_len = (mem_bcount_o == 4'd0) ? 4'd1 : mem_bcount_o;

    assign beat_ok = !reset && mem_readdatavalid_i && !empty;
    assign pop     = beat_ok && (beat_inc == tag_len_q[rd_q]);

    always_comb begin
        mem_read_o   = 1'b0;
        mem_addr_o   = '0;
        mem_bcount_o = '0;
        case (state_q)
            GNT_DESC: begin
                mem_read_o   = !reset;
                mem_addr_o   = desc_addr_i;
                mem_bcount_o = desc_bcount_i;
            end
            GNT_DATA: begin
                mem_read_o   = !reset;
                mem_addr_o   = data_addr_i;
                mem_bcount_o = data_bcount_i;
            end
            default: begin
                mem_read_o   = 1'b0;
            end
        endcase
    end

    assign desc_waitrequest_o = !(accept && (state_q == GNT_DESC));
    assign data_waitrequest_o = !(accept && (state_q == GNT_DATA));

    assign desc_rddata_o = mem_rddata_i;
    assign data_rddata_o = mem_rddata_i;

    assign desc_readdatavalid_o = beat_ok && (head_own == OWN_DESC);
    assign data_readdatavalid_o = beat_ok && (head_own == OWN_DATA);

    assign busy_o  = (state_q != IDLE) || !empty;
    assign error_o = err_q;

    // Ties go to whichever requester did not win last time
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (!full) begin
                    if (desc_read_i &&
                        (!data_read_i || last_q == OWN_DATA)) begin
                        state_d = GNT_DESC;
                        last_d  = OWN_DESC;
                    end else if (data_read_i) begin
                        state_d = GNT_DATA;
                        last_d  = OWN_DATA;
                    end
                end
            end
            GNT_DESC, GNT_DATA: begin
                if (!mem_waitrequest_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        beat_d = beat_q;
        err_d  = err_q;
        if (push) begin
            wr_d = wr_q + PTR_ONE;
        end
        if (pop) begin
            rd_d = rd_q + PTR_ONE;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        if (beat_ok) begin
            beat_d = pop ? 4'd0 : beat_inc;
        end
        if (mem_readdatavalid_i && empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= OWN_DATA;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Tag storage needs no reset; occupancy alone says what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            tag_own_q[wr_q] <= (state_q == GNT_DATA) ? OWN_DATA : OWN_DESC;
            tag_len_q[wr_q] <= acc_len;
        end
    end

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Randomised bench for dma_rd_arbiter against a queue-based
// model of grants, tag ownership and beat routing.
module tb_dma_rd_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        desc_read_i;
    logic [31:0] desc_addr_i;
    logic [3:0]  desc_bcount_i;
    logic        desc_waitrequest_o;
    logic [31:0] desc_rddata_o;
    logic        desc_readdatavalid_o;
    logic        data_read_i;
    logic [31:0] data_addr_i;
    logic [3:0]  data_bcount_i;
    logic        data_waitrequest_o;
    logic [31:0] data_rddata_o;
    logic        data_readdatavalid_o;
    logic        mem_read_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_bcount_o;
    logic        mem_waitrequest_i;
    logic [31:0] mem_rddata_i;
    logic        mem_readdatavalid_i;
    logic        busy_o;
    logic        error_o;

    always #5 clk = ~clk;

    dma_rd_arbiter #(.TAG_DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .reset                (reset),
        .desc_read_i          (desc_read_i),
        .desc_addr_i          (desc_addr_i),
        .desc_bcount_i        (desc_bcount_i),
        .desc_waitrequest_o   (desc_waitrequest_o),
        .desc_rddata_o        (desc_rddata_o),
        .desc_readdatavalid_o (desc_readdatavalid_o),
        .data_read_i          (data_read_i),
        .data_addr_i          (data_addr_i),
        .data_bcount_i        (data_bcount_i),
        .data_waitrequest_o   (data_waitrequest_o),
        .data_rddata_o        (data_rddata_o),
        .data_readdatavalid_o (data_readdatavalid_o),
        .mem_read_o           (mem_read_o),
        .mem_addr_o           (mem_addr_o),
        .mem_bcount_o         (mem_bcount_o),
        .mem_waitrequest_i    (mem_waitrequest_i),
        .mem_rddata_i         (mem_rddata_i),
        .mem_readdatavalid_i  (mem_readdatavalid_i),
        .busy_o               (busy_o),
        .error_o              (error_o)
    );

    typedef struct {
        int own;
        int beats;
    } tag_t;

    int checks = 0;
    int errors = 0;

    // reference model: -1 none, 0 desc, 1 data
    int   m_gnt  = -1;
    int   m_last = 1;
    tag_t m_q[$];
    int   m_cnt  = 0;
    bit   m_err  = 1'b0;

    // stimulus knobs and observations
    int   d_left = 0;
    int   a_left = 0;
    int   req_pct = 100;
    int   wait_pct = 0;
    int   wait_cnt = 0;
    int   ret_pct = 100;
    bit   ret_en = 1'b1;
    int   mem_pend[$];
    bit   d_acc = 1'b0;
    bit   a_acc = 1'b0;
    int   gnt_log[$];
    int   n_drv = 0;
    int   n_arv = 0;
    int   d_beats = 0;
    int   a_beats = 0;
    logic [31:0] last_a_addr = '0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mdl
        int          occ;
        bit          acc;
        logic [3:0]  bc;
        bit          exp_drv;
        bit          exp_arv;
        tag_t        t;
        if (reset) begin
            chk("rst_mem_read", mem_read_o, 0);
            chk("rst_desc_wait", desc_waitrequest_o, 1);
            chk("rst_data_wait", data_waitrequest_o, 1);
            chk("rst_desc_rdv", desc_readdatavalid_o, 0);
            chk("rst_data_rdv", data_readdatavalid_o, 0);
            m_gnt  = -1;
            m_last = 1;
            m_q.delete();
            m_cnt  = 0;
            m_err  = 1'b0;
        end else begin
            occ = m_q.size();
            chk("busy", busy_o, (m_gnt >= 0) || (occ > 0));
            chk("error", error_o, m_err);
            chk("mem_read", mem_read_o, m_gnt >= 0);
            acc = (m_gnt >= 0) && !mem_waitrequest_i;
            bc  = 4'd0;
            if (m_gnt == 0) begin
                chk("addr_desc", mem_addr_o, desc_addr_i);
                chk("bc_desc", mem_bcount_o, desc_bcount_i);
                bc = desc_bcount_i;
            end else if (m_gnt == 1) begin
                chk("addr_data", mem_addr_o, data_addr_i);
                chk("bc_data", mem_bcount_o, data_bcount_i);
                bc = data_bcount_i;
            end
            chk("desc_wait", desc_waitrequest_o, !(acc && m_gnt == 0));
            chk("data_wait", data_waitrequest_o, !(acc && m_gnt == 1));
            exp_drv = 1'b0;
            exp_arv = 1'b0;
            if (mem_readdatavalid_i) begin
                if (occ == 0) begin
                    m_err = 1'b1;
                end else begin
                    if (m_q[0].own == 0) exp_drv = 1'b1;
                    else exp_arv = 1'b1;
                    m_cnt++;
                    if (m_cnt == m_q[0].beats) begin
                        void'(m_q.pop_front());
                        m_cnt = 0;
                    end
                end
            end
            chk("desc_rdv", desc_readdatavalid_o, exp_drv);
            chk("data_rdv", data_readdatavalid_o, exp_arv);
            chk("desc_rddata", desc_rddata_o, mem_rddata_i);
            chk("data_rddata", data_rddata_o, mem_rddata_i);
            if (m_gnt >= 0) begin
                if (acc) begin
                    t.own   = m_gnt;
                    t.beats = (bc == 4'd0) ? 1 : int'(bc);
                    m_q.push_back(t);
                    m_gnt = -1;
                end
            end else if (occ < DEPTH) begin
                if (desc_read_i && data_read_i) m_gnt = 1 - m_last;
                else if (desc_read_i) m_gnt = 0;
                else if (data_read_i) m_gnt = 1;
                if (m_gnt >= 0) m_last = m_gnt;
            end
        end
        d_acc = !reset && !desc_waitrequest_o;
        a_acc = !reset && !data_waitrequest_o;
        if (d_acc) gnt_log.push_back(0);
        if (a_acc) gnt_log.push_back(1);
        if (!reset && mem_read_o && !mem_waitrequest_i)
            mem_pend.push_back((mem_bcount_o == 4'd0) ?
                               1 : int'(mem_bcount_o));
        if (desc_readdatavalid_o) n_drv++;
        if (data_readdatavalid_o) n_arv++;
    end

    task automatic issue(input int who,
                         input logic [31:0] a,
                         input logic [3:0] b);
        if (who == 0) begin
            desc_read_i   = 1'b1;
            desc_addr_i   = a;
            desc_bcount_i = b;
            d_beats += (b == 4'd0) ? 1 : int'(b);
        end else begin
            data_read_i   = 1'b1;
            data_addr_i   = a;
            data_bcount_i = b;
            a_beats += (b == 4'd0) ? 1 : int'(b);
            last_a_addr = a;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (d_acc) desc_read_i = 1'b0;
        if (a_acc) data_read_i = 1'b0;
        if (!desc_read_i && d_left > 0 &&
            $urandom_range(99) < req_pct) begin
            d_left--;
            issue(0, $urandom, 4'($urandom_range(15)));
        end
        if (!data_read_i && a_left > 0 &&
            $urandom_range(99) < req_pct) begin
            a_left--;
            issue(1, $urandom, 4'($urandom_range(15)));
        end
        if (wait_cnt > 0) begin
            mem_waitrequest_i = 1'b1;
            wait_cnt--;
        end else begin
            mem_waitrequest_i = ($urandom_range(99) < wait_pct);
        end
        mem_readdatavalid_i = 1'b0;
        if (ret_en && mem_pend.size() > 0 &&
            $urandom_range(99) < ret_pct) begin
            mem_readdatavalid_i = 1'b1;
            mem_rddata_i = $urandom;
            mem_pend[0]--;
            if (mem_pend[0] == 0) void'(mem_pend.pop_front());
        end
    endtask

    task automatic do_reset(input bit keep);
        reset       = 1'b1;
        desc_read_i = 1'b0;
        data_read_i = 1'b0;
        d_left   = 0;
        a_left   = 0;
        wait_pct = 0;
        wait_cnt = 0;
        req_pct  = 100;
        ret_pct  = 100;
        ret_en   = 1'b1;
        if (!keep) mem_pend.delete();
        repeat (2) tick();
        reset = 1'b0;
        gnt_log.delete();
        n_drv   = 0;
        n_arv   = 0;
        d_beats = 0;
        a_beats = 0;
    endtask

    task automatic drain(input int max);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            tick();
            done = d_left == 0 && a_left == 0 &&
                   !desc_read_i && !data_read_i &&
                   mem_pend.size() == 0 && !mem_readdatavalid_i &&
                   m_q.size() == 0 && m_gnt < 0;
        end
        chk("drain_timeout", done, 1);
    endtask

    initial begin
        reset               = 1'b1;
        desc_read_i         = 1'b0;
        desc_addr_i         = '0;
        desc_bcount_i       = '0;
        data_read_i         = 1'b0;
        data_addr_i         = '0;
        data_bcount_i       = '0;
        mem_waitrequest_i   = 1'b0;
        mem_rddata_i        = '0;
        mem_readdatavalid_i = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_err", error_o, 0);

        // single descriptor burst
        issue(0, 32'h1000, 4'd8);
        drain(200);
        chk("r31_desc_beats", n_drv, 8);
        chk("r31_data_beats", n_arv, 0);
        chk("r31_busy", busy_o, 0);

        // round-robin on simultaneous requests
        do_reset(0);
        d_left = 2;
        a_left = 2;
        drain(200);
        chk("r32_ngnt", gnt_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("r32_gnt%0d", i),
                (gnt_log.size() > i) ? gnt_log[i] : -1, i % 2);

        // grant locked while memory stalls
        do_reset(0);
        wait_cnt = 4;
        a_left   = 1;
        tick();
        d_left = 1;
        tick();
        tick();
        chk("r33_addr_hold", mem_addr_o, last_a_addr);
        chk("r33_desc_wait", desc_waitrequest_o, 1);
        tick();
        chk("r33_addr_hold2", mem_addr_o, last_a_addr);
        drain(200);
        chk("r33_ngnt", gnt_log.size(), 2);
        chk("r33_first", (gnt_log.size() > 0) ? gnt_log[0] : -1, 1);
        chk("r33_second", (gnt_log.size() > 1) ? gnt_log[1] : -1, 0);

        // tag FIFO full blocks further grants
        do_reset(0);
        ret_en = 1'b0;
        d_left = 3;
        a_left = 3;
        repeat (40) tick();
        chk("r34_full_gnts", gnt_log.size(), DEPTH);
        chk("r34_no_read", mem_read_o, 0);
        ret_en = 1'b1;
        drain(500);
        chk("r34_all_gnts", gnt_log.size(), 6);

        // interleaved routing
        do_reset(0);
        ret_en = 1'b0;
        issue(0, 32'h2000, 4'd8);
        issue(1, 32'h3000, 4'd2);
        repeat (10) tick();
        ret_en = 1'b1;
        drain(200);
        chk("r35_desc_beats", n_drv, 8);
        chk("r35_data_beats", n_arv, 2);

        // stray beat with nothing outstanding
        do_reset(0);
        mem_readdatavalid_i = 1'b1;
        mem_rddata_i = 32'hdead_beef;
        tick();
        chk("r36_err", error_o, 1);
        repeat (10) tick();
        chk("r36_sticky", error_o, 1);
        chk("r36_no_rdv", n_drv + n_arv, 0);

        // reset mid-burst orphans the remaining beats
        do_reset(0);
        ret_en = 1'b0;
        issue(0, 32'h4000, 4'd8);
        repeat (5) tick();
        ret_en = 1'b1;
        repeat (2) tick();
        do_reset(1);
        chk("r29_err_clr", error_o, 0);
        tick();
        chk("r29_err_set", error_o, 1);
        repeat (6) tick();
        chk("r29_no_rdv", n_drv + n_arv, 0);

        // random traffic
        do_reset(0);
        req_pct  = 40;
        wait_pct = 30;
        ret_pct  = 60;
        d_left   = 40;
        a_left   = 40;
        drain(6000);
        chk("rand_gnts", gnt_log.size(), 80);
        chk("rand_desc_beats", n_drv, d_beats);
        chk("rand_data_beats", n_arv, a_beats);
        chk("rand_err", error_o, 0);
        chk("rand_busy", busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_rd_arbiter.md
DMA_RD_ARBITER -- requirements
Module: dma_rd_arbiter

Interface
REQ-001 Parameter: TAG_DEPTH, 4, max accepted-but-incomplete bursts tracked (power of 2, >=2).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 desc_read_i / desc_addr_i / desc_bcount_i  input  1/32/4  descriptor-fetch requester burst-read command.
REQ-005 desc_waitrequest_o  output  1  stall to descriptor fetch; low only in the cycle its command is accepted.
REQ-006 desc_rddata_o / desc_readdatavalid_o  output  32/1  return beats routed to descriptor fetch.
REQ-007 data_read_i / data_addr_i / data_bcount_i  input  1/32/4  data-read requester burst-read command.
REQ-008 data_waitrequest_o  output  1  stall to data-read requester, same rule as REQ-005.
REQ-009 data_rddata_o / data_readdatavalid_o  output  32/1  return beats routed to data-read requester.
REQ-010 mem_read_o / mem_addr_o / mem_bcount_o  output  1/32/4  shared Avalon-MM burst-read command port.
REQ-011 mem_waitrequest_i  input  1  memory command stall.
REQ-012 mem_rddata_i / mem_readdatavalid_i  input  32/1  memory return data.
REQ-013 busy_o  output  1  high when state != IDLE or tag FIFO not empty.
REQ-014 error_o  output  1  sticky: return beat arrived with tag FIFO empty.

Function
REQ-015 FSM states: IDLE, GNT_DESC, GNT_DATA; registered state, reset to IDLE.
REQ-016 IDLE: if tag FIFO full -> stay IDLE; else if one requester asserts read -> its GNT state; if both -> requester not in last_grant.
REQ-017 last_grant register updated on entry to a GNT state; reset value = DATA (descriptor fetch wins first tie).
REQ-018 GNT_x: mem_read_o=1, mem_addr_o/mem_bcount_o combinationally muxed from requester x inputs; other requester's command ignored.
REQ-019 GNT_x with mem_waitrequest_i=1 -> hold GNT_x (grant locked); with 0 -> command accepted, x_waitrequest_o=0 that cycle, next state IDLE.
REQ-020 mem_read_o=0 in IDLE; both waitrequest_o=1 except per REQ-019; minimum 1 idle cycle between accepted commands.
REQ-021 Arbitration latency: request seen in IDLE -> mem_read_o asserted the next cycle.
REQ-022 On acceptance push {owner, bcount} into tag FIFO (depth TAG_DEPTH); bcount 0 stored as 1 beat.
REQ-023 Return: mem_readdatavalid_i routed to head-tag owner's readdatavalid_o; both rddata_o = mem_rddata_i unconditionally; non-owner readdatavalid_o=0.
REQ-024 Beat counter (4-bit) increments per valid beat; on beat == head bcount, pop tag and clear counter in same cycle.
REQ-025 Push and pop in same cycle: both occur, occupancy unchanged; full check in IDLE uses current occupancy (no pop look-ahead).
REQ-026 Valid beat with tag FIFO empty: dropped, no readdatavalid_o, error_o set until reset.
REQ-027 Requester deasserting read while granted and waitrequest high is a protocol violation; behaviour undefined.

Reset
REQ-028 reset forces IDLE, last_grant=DATA, tag FIFO empty, beat counter 0, error_o=0, busy_o=0.
REQ-029 Reset mid-burst discards outstanding tags; subsequent return beats set error_o per REQ-026.
REQ-030 Outputs during reset: mem_read_o=0, both waitrequest_o=1, both readdatavalid_o=0.

Verification
REQ-031 desc only, addr 0x1000, bcount 8, mem_waitrequest 0 -> mem_read_o 1 cycle after request, addr 0x1000; 8 beats all on desc_readdatavalid_o, then busy_o=0.
REQ-032 Both request simultaneously twice -> grants DESC, DATA, DESC, DATA in order.
REQ-033 mem_waitrequest_i high 3 cycles during GNT_DATA while desc requests -> mem_addr_o stays data_addr_i, desc granted only after acceptance.
REQ-034 TAG_DEPTH=4, 4 bursts accepted, no returns -> no 5th mem_read_o; one burst completes -> next grant proceeds.
REQ-035 Interleaved: desc bcount 8 then data bcount 2 accepted -> first 8 beats to desc, next 2 to data, no misrouting.
REQ-036 Return beat with empty FIFO -> both readdatavalid_o 0, error_o=1 and stays 1 until reset.
